// File: rtl/md_sequencer.sv
// Multiply/divide sequencer beside the E-stage ALU: owns HI/LO, computes the result at
// issue and commits it after a fixed MULT/DIV latency while busy is held high.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;
    logic          busy_q, busy_d;

    logic [63:0] mul_s, mul_u;
    logic [31:0] a_mag, b_mag, b_safe, b_safe_u;
    logic [31:0] q_mag, r_mag, s_quo, s_rem, u_quo, u_rem;

    // Signed divide works on magnitudes so 0x80000000 / -1 needs no overflow special case.
    always_comb begin
        mul_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        mul_u    = {32'b0, a} * {32'b0, b};
        a_mag    = a[31] ? (32'd0 - a) : a;
        b_mag    = b[31] ? (32'd0 - b) : b;
        b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        b_safe_u = (b == 32'd0) ? 32'd1 : b;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        s_quo    = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        s_rem    = a[31] ? (32'd0 - r_mag) : r_mag;
        u_quo    = a / b_safe_u;
        u_rem    = a % b_safe_u;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = mul_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = mul_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = s_rem;
                            pend_lo_d = s_quo;
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = u_rem;
                            pend_lo_d = u_quo;
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = DIV_LOAD;
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // A new start here is ignored; the hazard unit keeps D stalled.
                if (abort) begin
                    pend_wr_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == '0) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_wr_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed scenarios plus random ops checked against a
// longint-arithmetic model of the HI/LO results and the fixed busy latency.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    // Reference architectural HI/LO and expected commit values (hi then lo).
    logic [31:0] m_hi, m_lo;
    logic [31:0] exp_q[$];

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int md_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return 5;
            3'd2, 3'd3: return 10;
            default:    return 0;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = 64'(x) * 64'(y); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: if (y != 0) begin
                q = sx / sy; r = sx % sy;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issue one op; optionally try an MTLO during RUN, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit mt_during);
        int          n;
        logic [31:0] old_hi, old_lo;
        n      = md_cycles(o);
        old_hi = m_hi;
        old_lo = m_lo;
        model_apply(o, x, y);
        exp_q.push_back(m_hi);
        exp_q.push_back(m_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd7; a = $urandom(); b = $urandom();
        for (int i = 1; i <= n; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold_hi"}, hi, old_hi);
            check({tag, "_hold_lo"}, lo, old_lo);
            if (mt_during && i == 2) begin
                start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, exp_q.pop_front());
        check({tag, "_lo"}, lo, exp_q.pop_front());
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 3'd0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mthi", 3'd4, 32'h0000_1234, 32'd0, 1'b0);
        run_op("mtlo", 3'd5, 32'h0000_5678, 32'd0, 1'b0);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", lo, 32'hFFFF_FFFA);
        run_op("b2b_mult", 3'd0, 32'd7, 32'd9, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_hi_const", hi, 32'd1);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        check("div_neg_hi_const", hi, 32'hFFFF_FFFF);
        run_op("set_hi", 3'd4, 32'h11, 32'd0, 1'b0);
        run_op("set_lo", 3'd5, 32'h22, 32'd0, 1'b0);
        run_op("divu_zero", 3'd3, 32'd100, 32'd0, 1'b0);
        check("divu_zero_hi_const", hi, 32'h11);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        run_op("mtlo_in_run", 3'd1, 32'd1000, 32'd3, 1'b1);
        run_op("undef_op", 3'd6, 32'hAAAA_AAAA, 32'd5, 1'b0);

        // Abort at the third busy cycle: nothing commits, then or later.
        @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; check("abort_busy_pre", 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, m_hi);
        check("abort_lo", lo, m_lo);
        repeat (6) @(posedge clk);
        #1;
        check("abort_late_hi", hi, m_hi);
        check("abort_late_lo", lo, m_lo);

        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1; op = 3'd2; a = 32'd50; b = 32'd7;
        @(posedge clk); #1;
        check("sa_div_busy", 32'(busy), 32'd0);
        op = 3'd4; a = 32'hCAFE_0000;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        check("sa_mthi_busy", 32'(busy), 32'd0);
        check("sa_hi", hi, m_hi);
        check("sa_lo", lo, m_lo);

        // Reset during a DIV at its fourth busy cycle.
        run_op("pre_rst", 3'd4, 32'h7777, 32'd0, 1'b0);
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd4;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mrst_after_busy", 32'(busy), 32'd0);
        check("mrst_after_hi", hi, 32'd0);
        check("mrst_after_lo", lo, 32'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom();
            case ($urandom_range(0, 5))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 7));
                default: ry = $urandom();
            endcase
            run_op("rand", ro, rx, ry, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
